// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressable word memory with clear-on-reset sweep, sized access and fault counting
module data_memory_sized #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          FAULT_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            address,
  input  logic [1:0]             accessSize,
  input  logic                   signedLoad,
  input  logic                   readEnabled,
  input  logic                   writeEnabled,
  input  logic [31:0]            writeInput,
  output logic [31:0]            readResult,
  output logic                   readValid,
  output logic                   busy,
  output logic                   fault,
  output logic [FAULT_CNT_W-1:0] faultCount
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_sweep;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] w_off, w_word, w_shift, w_wdata, w_rdata;
  logic [AW-1:0] w_idx;
  logic [3:0] w_be;
  logic w_bad, w_rd, w_wr, w_fault;
  always_ff @(posedge clock) begin
    if (reset) r_state <= CLEAR;
    else r_state <= w_next;
  end
  always_comb begin
    busy = r_state == CLEAR;
    w_next = (busy && r_sweep == AW'(DEPTH - 1)) ? READY : r_state;
  end
  assign w_off = address - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];
  assign w_bad = accessSize == 2'b11 || (accessSize == 2'b01 && w_off[0]) ||
                 (accessSize == 2'b10 && |w_off[1:0]) || address < BASE_ADDR ||
                 w_off[31:2] >= 30'(DEPTH);
  assign w_rd = !busy && readEnabled && !w_bad;
  assign w_wr = !busy && writeEnabled && !w_bad;
  // a simultaneous bad read and bad write is a single rejected request
  assign w_fault = !busy && (readEnabled || writeEnabled) && w_bad;
  assign w_be = accessSize == 2'b00 ? 4'b0001 << w_off[1:0] :
                accessSize == 2'b01 ? 4'b0011 << w_off[1:0] : 4'b1111;
  assign w_wdata = accessSize == 2'b00 ? {4{writeInput[7:0]}} :
                   accessSize == 2'b01 ? {2{writeInput[15:0]}} : writeInput;
  assign w_word = r_mem[w_idx];
  assign w_shift = w_word >> {w_off[1:0], 3'b000};
  assign w_rdata = accessSize == 2'b00 ? {{24{signedLoad & w_shift[7]}}, w_shift[7:0]} :
                   accessSize == 2'b01 ? {{16{signedLoad & w_shift[15]}}, w_shift[15:0]} : w_word;
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (busy) r_mem[r_sweep] <= '0;
      else if (w_wr)
        for (int b = 0; b < 4; b++)
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) r_sweep <= '0;
    else if (busy) r_sweep <= r_sweep + 1'b1;
  end
  // read data is taken from the pre-write word, giving read-before-write on collisions
  always_ff @(posedge clock) begin
    if (reset) begin
      readResult <= '0;
      readValid  <= 1'b0;
      fault      <= 1'b0;
      faultCount <= '0;
    end else begin
      readValid <= w_rd;
      fault     <= w_fault;
      if (w_rd) readResult <= w_rdata;
      if (w_fault && !(&faultCount)) faultCount <= faultCount + 1'b1;
    end
  end
endmodule

// File: doc/data_memory_sized.md
DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter BASE_ADDR, default 32'h00000000: byte address of word 0; word-aligned.
REQ-003 Parameter FAULT_CNT_W, default 16: width of faultCount.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high; starts the memory clear sweep.
REQ-006 address  input  32  byte address of the access.
REQ-007 accessSize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 signedLoad  input  1  reads: 1 = sign-extend, 0 = zero-extend the sub-word result.
REQ-009 readEnabled  input  1  read request, sampled each cycle.
REQ-010 writeEnabled  input  1  write request, sampled each cycle.
REQ-011 writeInput  input  32  write data; the byte/half value sits in the low bits.
REQ-012 readResult  output  32  registered read data.
REQ-013 readValid  output  1  one-cycle pulse; readResult is valid in that cycle.
REQ-014 busy  output  1  high while the clear sweep runs; requests are ignored.
REQ-015 fault  output  1  one-cycle pulse for a rejected request.
REQ-016 faultCount  output  FAULT_CNT_W  saturating count of rejected requests.

Function
REQ-017 The block SHALL have two states: CLEAR and READY.
REQ-018 CLEAR: the block SHALL write zero to one word per cycle, from index 0 to DEPTH-1, then enter READY on the following edge; the sweep lasts DEPTH cycles and busy=1 throughout.
REQ-019 READY: busy=0 and requests are accepted; READY SHALL leave only on reset.
REQ-020 Any request presented while busy=1 SHALL be ignored, with no fault and no count.
REQ-021 Byte index: offset = address - BASE_ADDR; word index = offset[31:2]; lane = offset[1:0]; storage is little-endian.
REQ-022 A request SHALL be rejected when any of the following holds: accessSize=11; half access with lane[0]=1; word access with lane!=0; address<BASE_ADDR; word index>=DEPTH.
REQ-023 A rejected request SHALL perform no memory access, pulse fault in the next cycle, increment faultCount (saturating at all-ones), and leave readValid=0.
REQ-024 Read and write requested in the same cycle and both rejected SHALL count as one fault.
REQ-025 Write: on the accepting edge, only the addressed lanes SHALL be updated: byte writes writeInput[7:0]; half writes writeInput[15:0]; word writes all 32 bits.
REQ-026 Read latency SHALL be 1 cycle: request at edge N gives readResult and readValid=1 after edge N+1.
REQ-027 Sub-word reads SHALL be right-justified and extended to 32 bits according to signedLoad; word reads ignore signedLoad.
REQ-028 Read and write accepted in the same cycle to the same word SHALL return the pre-write contents (read-before-write).
REQ-029 readResult SHALL hold its last value when readValid=0.

Reset
REQ-030 Reset at any edge, including mid-sweep or mid-access, SHALL on that edge: set the state to CLEAR, restart the sweep at index 0, and clear readResult, readValid, fault and faultCount.
REQ-031 A read pending at reset SHALL be discarded; no readValid pulse follows it.
REQ-032 Reset held high SHALL keep the sweep at index 0 and busy=1.

Verification
REQ-033 Reset for 1 cycle, DEPTH=16 -> busy=1 for exactly 16 cycles; a word read of every address then returns 32'h00000000.
REQ-034 Word write A5A5A5A5 to 0x4; byte write 0x7F to 0x5; signed byte read 0x4 -> 0xFFFFFFA5; unsigned half read 0x4 -> 0x00007FA5; word read 0x4 -> 0xA5A57FA5.
REQ-035 Signed half read at 0x6 after the writes above -> 0xFFFFA5A5; word read at 0x6 -> fault pulse, faultCount=1, no readValid; accessSize=11 -> faultCount=2.
REQ-036 Same-cycle word write 0x12345678 and word read at 0x8, which holds 0 -> readResult=0; the next read -> 0x12345678.
REQ-037 Address BASE_ADDR+4*DEPTH -> fault; FAULT_CNT_W=2 with 5 faults -> faultCount=3.
REQ-038 Reset asserted mid-sweep at index 9 -> sweep restarts at 0 and busy=1 for a further DEPTH cycles; a read issued the cycle before reset produces no readValid.
